// File: rtl/mips_cpu_instr_memory.sv
// Byte-serial preloadable instruction ROM for the CPU fetch port.
// Loader takes one byte per cycle while loading; fetch reads are combinational (0-cycle).
module mips_cpu_instr_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  input  logic [7:0]                   load_byte,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         load_done,
  output logic                         load_error,
  output logic [$clog2(DEPTH_WORDS):0] word_count,
  input  logic [31:0]                  instr_address,
  output logic [31:0]                  instr_readdata,
  output logic                         fetch_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {LOAD, READY, ERROR} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_idx;
  logic [23:0] hold;
  logic [31:0] mem [DEPTH_WORDS];

  logic        xfer;
  logic        full;
  logic        commit;
  logic        wr_en;
  logic [31:0] word;
  logic [31:0] offset;
  logic        in_range;
  logic [31:0] fetch_word;

  assign load_ready = (state == LOAD);
  assign load_done  = (state == READY);
  assign load_error = (state == ERROR);

  assign xfer   = load_valid && load_ready;
  assign full   = (word_count == CW'(DEPTH_WORDS));
  assign word   = {hold, load_byte};
  assign commit = xfer && (byte_idx == 2'd3) && !full;
  // Reset has priority over a same-edge transfer, including the array write.
  assign wr_en  = reset && commit;

  always_comb begin
    state_nxt = state;
    if (state == LOAD && xfer) begin
      if (byte_idx == 2'd3 && full) begin
        state_nxt = ERROR;
      end else if (load_last) begin
        state_nxt = (byte_idx == 2'd3) ? READY : ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= LOAD;
      byte_idx   <= 2'd0;
      hold       <= 24'd0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        hold     <= word[23:0];
        byte_idx <= byte_idx + 2'd1;
      end
      if (commit) begin
        word_count <= word_count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_count[AW-1:0]] <= word;
    end
  end

  // Unsigned offset: addresses below BASE_ADDR wrap high and fall out of range.
  assign offset     = instr_address - BASE_ADDR;
  assign in_range   = offset < (32'(word_count) << 2);
  assign fetch_word = mem[offset[AW+1:2]];

  always_comb begin
    instr_readdata = 32'd0;
    fetch_fault    = 1'b0;
    if (state != READY) begin
      fetch_fault = (state == ERROR);
    end else if (instr_address == 32'd0) begin
      fetch_fault = 1'b0;
    end else if (instr_address[1:0] != 2'd0) begin
      fetch_fault = 1'b1;
    end else if (!in_range) begin
      fetch_fault = 1'b1;
    end else begin
      instr_readdata = {fetch_word[7:0], fetch_word[15:8],
                        fetch_word[23:16], fetch_word[31:24]};
    end
  end

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Bench for mips_cpu_instr_memory: two instances (64 and 4 words) share stimulus
// and are compared every cycle against a byte-queue reference model.
module tb_mips_cpu_instr_memory;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'd0;
  logic        load_last = 1'b0;
  logic [31:0] instr_address = 32'd0;

  logic        ready0, done0, err0, ff0;
  logic [6:0]  wc0;
  logic [31:0] rd0;
  logic        ready1, done1, err1, ff1;
  logic [2:0]  wc1;
  logic [31:0] rd1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: every accepted byte since reset, plus per-instance state (0 load, 1 ready, 2 error).
  logic [7:0] q[$];
  int         mst[2];
  int         mcount[2];
  int         dep[2] = '{64, 4};
  bit         started = 1'b0;
  bit         rand_addr = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_instr_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(64)) dut0 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(ready0), .load_done(done0), .load_error(err0),
    .word_count(wc0), .instr_address(instr_address), .instr_readdata(rd0),
    .fetch_fault(ff0)
  );

  mips_cpu_instr_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(4)) dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(ready1), .load_done(done1), .load_error(err1),
    .word_count(wc1), .instr_address(instr_address), .instr_readdata(rd1),
    .fetch_fault(ff1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_fetch(input int i, input logic [31:0] a,
                                      output logic [31:0] rd, output logic ff);
    logic [31:0] off;
    int k;
    rd  = 32'd0;
    ff  = 1'b0;
    off = a - BASE;
    k   = int'(off >> 2);
    if (mst[i] != 1) ff = (mst[i] == 2);
    else if (a == 32'd0) ff = 1'b0;
    else if (a[1:0] != 2'd0) ff = 1'b1;
    else if (off >= 32'(4 * mcount[i])) ff = 1'b1;
    else rd = {q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]};
  endfunction

  always @(posedge clk) begin
    int n;
    if (!reset) begin
      q.delete();
      mst     = '{0, 0};
      mcount  = '{0, 0};
      started = 1'b1;
    end else if (load_valid) begin
      if (mst[0] == 0 || mst[1] == 0) q.push_back(load_byte);
      for (int i = 0; i < 2; i++) begin
        if (mst[i] == 0) begin
          n = q.size();
          if (n % 4 == 0 && n / 4 > dep[i]) begin
            mst[i] = 2;
          end else begin
            mcount[i] = n / 4;
            if (load_last) mst[i] = (n % 4 == 0) ? 1 : 2;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] erd;
    logic        eff;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        model_fetch(i, instr_address, erd, eff);
        check($sformatf("ready%0d", i), 32'(i == 0 ? ready0 : ready1), 32'(mst[i] == 0));
        check($sformatf("done%0d", i),  32'(i == 0 ? done0 : done1),   32'(mst[i] == 1));
        check($sformatf("error%0d", i), 32'(i == 0 ? err0 : err1),     32'(mst[i] == 2));
        check($sformatf("count%0d", i), (i == 0) ? 32'(wc0) : 32'(wc1), 32'(mcount[i]));
        check($sformatf("rdata%0d", i), (i == 0) ? rd0 : rd1, erd);
        check($sformatf("fault%0d", i), 32'(i == 0 ? ff0 : ff1), 32'(eff));
      end
    end
  end

  function automatic logic [31:0] pick_addr();
    case ($urandom % 6)
      0:       return BASE + 32'(4 * $urandom_range(0, 70));
      1:       return BASE + 32'(4 * $urandom_range(0, 5));
      2:       return 32'd0;
      3:       return BASE + 32'($urandom_range(0, 300));
      4:       return BASE - 32'(4 * $urandom_range(1, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic xfer(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    if (rand_addr) instr_address = pick_addr();
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rand_addr) instr_address = pick_addr();
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    if (rand_addr) begin
      load_valid = 1'($urandom);
      load_byte  = 8'($urandom);
    end
    @(posedge clk); #1;
    reset      = 1'b1;
    load_valid = 1'b0;
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] a,
                           input logic [31:0] exp_rd, input logic exp_ff);
    instr_address = a;
    @(negedge clk);
    check({name, "_rd"}, rd0, exp_rd);
    check({name, "_ff"}, 32'(ff0), 32'(exp_ff));
    @(posedge clk); #1;
  endtask

  logic [7:0] prog [20] = '{8'h24, 8'h21, 8'h00, 8'h05, 8'h00, 8'h20, 8'h00, 8'h13,
                            8'h00, 8'h00, 8'h10, 8'h12, 8'h00, 8'h00, 8'h00, 8'h08,
                            8'h24, 8'h00, 8'h00, 8'h00};

  initial begin
    int len;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_done",  32'(done0),  32'd0);
    check("rst_error", 32'(err0),   32'd0);
    check("rst_count", 32'(wc0),    32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Program image: fits in the 64-word instance, overflows the 4-word one.
    for (int i = 0; i < 20; i++) xfer(prog[i], i == 19);
    @(negedge clk);
    check("mtlo_done",   32'(done0), 32'd1);
    check("mtlo_count",  32'(wc0),   32'd5);
    check("ovf_error",   32'(err1),  32'd1);
    check("ovf_count",   32'(wc1),   32'd4);
    @(posedge clk); #1;
    fetch_chk("w0",   32'hBFC00000, 32'h05002124, 1'b0);
    fetch_chk("w1",   32'hBFC00004, 32'h13002000, 1'b0);
    fetch_chk("w4",   32'hBFC00010, 32'h00000024, 1'b0);
    fetch_chk("past", 32'hBFC00014, 32'h0, 1'b1);
    fetch_chk("mis",  32'hBFC00002, 32'h0, 1'b1);
    fetch_chk("halt", 32'h00000000, 32'h0, 1'b0);
    fetch_chk("below", 32'hBFBFFFFC, 32'h0, 1'b1);

    // Loader traffic in READY is ignored.
    xfer(8'hAA, 1'b0);
    xfer(8'hBB, 1'b1);
    @(negedge clk);
    check("ready_ign_count", 32'(wc0), 32'd5);
    @(posedge clk); #1;
    fetch_chk("ready_ign_w0", 32'hBFC00000, 32'h05002124, 1'b0);

    // Short image: last on byte 6.
    do_reset();
    for (int i = 0; i < 6; i++) xfer(8'(i + 1), i == 5);
    @(negedge clk);
    check("short_error", 32'(err0),   32'd1);
    check("short_count", 32'(wc0),    32'd1);
    check("short_ready", 32'(ready0), 32'd0);
    @(posedge clk); #1;
    fetch_chk("short_fetch", 32'hBFC00000, 32'h0, 1'b1);
    do_reset();
    @(negedge clk);
    check("short_cleared", 32'(err0), 32'd0);
    @(posedge clk); #1;

    // Overflow without load_last on the 4-word instance.
    for (int i = 0; i < 20; i++) xfer(8'($urandom), 1'b0);
    @(negedge clk);
    check("ovf2_error", 32'(err1), 32'd1);
    check("ovf2_count", 32'(wc1),  32'd4);
    @(posedge clk); #1;

    // Reset while a transfer is presented.
    do_reset();
    for (int i = 0; i < 7; i++) xfer(8'($urandom), 1'b0);
    load_valid = 1'b1;
    load_byte  = 8'h5A;
    reset      = 1'b0;
    @(posedge clk); #1;
    reset      = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    check("midrst_count", 32'(wc0),    32'd0);
    check("midrst_ready", 32'(ready0), 32'd1);
    @(posedge clk); #1;
    xfer(8'h11, 1'b0); xfer(8'h22, 1'b0); xfer(8'h33, 1'b0); xfer(8'h44, 1'b1);
    @(negedge clk);
    check("fresh_count", 32'(wc0),   32'd1);
    check("fresh_done",  32'(done0), 32'd1);
    @(posedge clk); #1;
    fetch_chk("fresh_w0", 32'hBFC00000, 32'h44332211, 1'b0);

    // Gapped reload produces the same words as a gapless one.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(0, 3));
      xfer(prog[i], i == 19);
    end
    fetch_chk("gap_w0", 32'hBFC00000, 32'h05002124, 1'b0);
    fetch_chk("gap_w1", 32'hBFC00004, 32'h13002000, 1'b0);
    fetch_chk("gap_w2", 32'hBFC00008, 32'h12100000, 1'b0);
    fetch_chk("gap_w3", 32'hBFC0000C, 32'h08000000, 1'b0);
    fetch_chk("gap_w4", 32'hBFC00010, 32'h00000024, 1'b0);

    // Randomized images, gaps, last placement and fetch addresses.
    rand_addr = 1'b1;
    for (int it = 0; it < 40; it++) begin
      do_reset();
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        if ($urandom % 4 == 0) idle($urandom_range(1, 2));
        xfer(8'($urandom), (j == len - 1) && ($urandom % 8 != 0));
      end
      idle(10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_instr_memory.md
# mips_cpu_instr_memory

Preloadable instruction memory that answers the Harvard CPU's instruction-fetch port. It sits between a byte-serial loader (bench or boot controller) and the CPU's `instr_address`/`instr_readdata` pins. It assembles loaded bytes into words, stores them from the reset vector upward, and returns them combinationally in the CPU's byte-swapped bus order. The CPU is held in reset until `load_done` is asserted.

## Interface
- `BASE_ADDR`, default 32'hBFC00000: byte address of word 0 (the reset vector).
- `DEPTH_WORDS`, default 64: storage size in 32-bit words; must be a power of two and at least 4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset: sampled on the rising edge of `clk`, and asserted when 0.
- `load_valid`  in  1  loader presents a byte.
- `load_byte`  in  8  byte value; the first byte of each word is the instruction MSB.
- `load_last`  in  1  qualifies the final byte of the image; only meaningful with `load_valid`.
- `load_ready`  out  1  block accepts a byte this cycle.
- `load_done`  out  1  image complete and valid; fetches are served.
- `load_error`  out  1  image rejected; sticky until reset.
- `word_count`  out  $clog2(DEPTH_WORDS)+1  number of complete words stored.
- `instr_address`  in  32  CPU fetch byte address.
- `instr_readdata`  out  32  fetched word, byte-swapped to CPU bus order.
- `fetch_fault`  out  1  the current fetch address is not servable.

## Operation
- **States:** LOAD, READY, ERROR. Reset enters LOAD.
- **Reset values:**
  - `load_ready`=1; `load_done`=0; `load_error`=0; `word_count`=0.
  - Byte index=0; holding register=0.
  - Array contents are not cleared.
- **Byte transfer:** a byte moves when `load_valid`&&`load_ready` at a rising edge.
- **Word assembly:** the holding register shifts left by 8 and ORs in the byte; the byte index increments mod 4.
- **Word commit:** on the 4th byte (index 3), the assembled word {b0,b1,b2,b3} is written to array[`word_count`], and `word_count` increments.
- **LOAD transitions:**
  - Transfer with `load_last` at index 3: commit the word, then go to READY.
  - Transfer with `load_last` at index 0–2: go to ERROR. The partial word is discarded and `word_count` is unchanged.
  - Transfer at index 3 when `word_count`==`DEPTH_WORDS` (array already full): go to ERROR with no write.
  - Because of the overflow rule, `word_count` never exceeds `DEPTH_WORDS`.
- **READY:** `load_ready`=0, `load_done`=1. Loader inputs are ignored.
- **ERROR:** `load_ready`=0, `load_error`=1. Fetches return 0 with `fetch_fault`=1. Only reset leaves this state.
- **Fetch decode** is combinational on `instr_address`, with offset = `instr_address` − `BASE_ADDR`.
  - Not READY: readdata=0. `fetch_fault`=0 in LOAD, 1 in ERROR.
  - `instr_address`==0 (CPU halt address): readdata=0, `fetch_fault`=0.
  - `instr_address`[1:0]≠0: readdata=0, `fetch_fault`=1.
  - offset ≥ 4×`word_count` (including negative offset / wrap-around): readdata=0, `fetch_fault`=1.
  - Otherwise, with w = array[offset>>2]: readdata={w[7:0],w[15:8],w[23:16],w[31:24]}, `fetch_fault`=0.

## Timing
- **Fetch latency:** 0 cycles. `instr_readdata` and `fetch_fault` settle within the same cycle as `instr_address`, because the CPU samples the fetch port in the cycle it issues the address.
- **Loader throughput:** one byte per cycle. `load_ready` depends only on state, never on `load_valid`.
- **Status outputs:** `load_done` and `load_error` go high on the edge after the final transfer. `word_count` updates on that same edge.
- **Reset mid-load:** the synchronous reset wins over a simultaneous transfer. The partial word and count are dropped and the state returns to LOAD next cycle. Old array contents are not readable, since `word_count`=0.
- **Inputs held in reset:** `load_valid` asserted while `reset`=0 causes no transfer.

## Test plan
- **Mtlo-style program:** load 20 bytes (24 21 00 05, 00 20 00 13, 00 00 10 12, 00 00 00 08, 24 00 00 00), `load_last` on byte 20.
  - `load_done`=1 one cycle later; `word_count`=5.
  - `instr_address`=BFC00000 -> 0x05002124; BFC00004 -> 0x13002000; BFC00010 -> 0x00000024; all with `fetch_fault`=0.
- **Fetch bounds:** after the program above, address BFC00014 -> 0, fault=1; BFC00002 -> 0, fault=1; 0x00000000 -> 0, fault=0; BFBFFFFC -> 0, fault=1.
- **Short image:** `load_last` on byte 6 -> `load_error`=1, `word_count`=1, `load_ready`=0. Fetch at BFC00000 -> 0, fault=1. Reset clears the error.
- **Overflow:** with `DEPTH_WORDS`=4, stream 20 bytes with no `load_last` -> error on byte 20; `word_count`=4.
- **Mid-load reset:** drive reset low after 7 bytes with `load_valid` still high -> `word_count`=0, state LOAD. A fresh 4-byte image then loads with `word_count`=1.
- **Backpressure and stalls:** in READY, pulse `load_valid` with a byte -> no change to `word_count` or memory. Gaps in `load_valid` during LOAD -> the assembled words are identical to a gapless load.
